// File: rtl/euler_pkg.sv
// Shared definitions for the prime-search sequencer: state encoding,
// candidate stepping constants and default sizing.
package euler_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_EVAL      = 3'd4,
    S_FINISH    = 3'd5
  } state_e;

  localparam int unsigned FIRST_PRIME = 2;
  localparam int unsigned ODD_STEP    = 2;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_TIMEOUT = 1000000;

endpackage

// File: rtl/hs_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and
// saturates once the limit is reached, holding expired high.
module hs_watchdog #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LIMIT);

  // Next count: clear wins, then count up until the limit and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nth_prime_seq.sv
// N-th prime sequencer: walks candidates 2,3,5,7,... through an external
// primality tester over a start/done handshake and stops at the N-th prime.
module nth_prime_seq
  import euler_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             error,
  output logic [WIDTH-1:0] cand_value,
  output logic             cand_start,
  input  logic             cand_done,
  input  logic             cand_result
);

  // Largest candidate that can still take an odd step without wrapping.
  localparam logic [WIDTH-1:0] LAST_SAFE = '1 - WIDTH'(ODD_STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             fin_q, fin_d;

  logic             accept;
  logic             wd_expired;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] cand_next;
  logic             hit;
  logic             ovf;

  // fin_q marks the first IDLE cycle after FINISH, when done has just risen;
  // a start landing on that cycle is deliberately dropped.
  assign accept    = (state_q == S_IDLE) && start && !fin_q;
  assign count_inc = cand_result ? (count_q + WIDTH'(1)) : count_q;
  assign hit       = cand_result && (count_inc == n_q);
  assign cand_next = (cand_q == WIDTH'(FIRST_PRIME)) ? (cand_q + WIDTH'(1))
                                                     : (cand_q + WIDTH'(ODD_STEP));
  assign ovf       = (cand_q != WIDTH'(FIRST_PRIME)) && (cand_q > LAST_SAFE);

  hs_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == S_ISSUE),
    .enable  ((state_q == S_WAIT_LOW) || (state_q == S_WAIT_DONE)),
    .expired (wd_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cand_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      fin_q    <= fin_d;
    end
  end

  // Next-state logic; a watchdog expiry in either wait state aborts the search.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (accept) state_d = (n == '0) ? S_FINISH : S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_LOW;
      S_WAIT_LOW:  if (wd_expired)     state_d = S_FINISH;
                   else if (!cand_done) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (wd_expired)     state_d = S_FINISH;
                   else if (cand_done) state_d = S_EVAL;
      S_EVAL:      state_d = (hit || ovf) ? S_FINISH : S_ISSUE;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and status updates for each state.
  always_comb begin
    n_d      = n_q;
    cand_d   = cand_q;
    count_d  = count_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;
    error_d  = error_q;
    fin_d    = (state_q == S_FINISH);
    unique case (state_q)
      S_IDLE: if (accept) begin
        n_d      = n;
        cand_d   = WIDTH'(FIRST_PRIME);
        count_d  = '0;
        result_d = '0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        error_d  = (n == '0);
      end
      S_WAIT_LOW, S_WAIT_DONE: if (wd_expired) begin
        error_d  = 1'b1;
        result_d = '0;
      end
      S_EVAL: begin
        count_d = count_inc;
        if (hit) begin
          result_d = cand_q;
        end else if (ovf) begin
          error_d  = 1'b1;
          result_d = '0;
        end else begin
          cand_d = cand_next;
        end
      end
      S_FINISH: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs: cand_start decodes straight from state so reset drops it at once.
  always_comb begin
    cand_start = (state_q == S_ISSUE);
    cand_value = cand_q;
    busy       = busy_q;
    done       = done_q;
    result     = result_q;
    error      = error_q;
  end

endmodule
